// File: rtl/op_sequencer.sv
// Three-state instruction sequencer: accepts a word in IDLE, presents it in EXEC
// (stallable) and WB, then latches ALU flags and counts the retired instruction.
module op_sequencer #(
    parameter logic [7:0] ADDC_OP = 8'h57,
    parameter logic [7:0] SUBC_OP = 8'h97,
    parameter logic [7:0] CMP_OP  = 8'hB0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] InstrIn,
    input  logic        InstrValid,
    output logic        InstrReady,
    input  logic        Stall,
    input  logic [4:0]  Flags,
    output logic [15:0] Opcode,
    output logic        Cin,
    output logic        RegWrEn,
    output logic [4:0]  Psr,
    output logic [15:0] InstrCount,
    output logic [1:0]  StateDbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]  state;
    logic [15:0] ir;
    logic [4:0]  psr_q;
    logic [15:0] count_q;
    logic [7:0]  alu_code;
    logic        carry_op;

    // Handshake: InstrIn is consumed on a rising edge where InstrValid and
    // InstrReady are both 1; the fetch side must hold the word until then.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ir      <= 16'h0000;
            psr_q   <= 5'h00;
            count_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (InstrValid) begin
                        ir    <= InstrIn;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!Stall) begin
                        state <= WB;
                    end
                end
                WB: begin
                    psr_q   <= Flags;
                    count_q <= count_q + 16'd1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_code = {ir[15:12], ir[7:4]};
    assign carry_op = (alu_code == ADDC_OP) || (alu_code == SUBC_OP);

    // All outputs decode from state so an asynchronous reset clears them at once.
    always_comb begin
        InstrReady = 1'b0;
        Opcode     = 16'h0000;
        Cin        = 1'b0;
        RegWrEn    = 1'b0;
        case (state)
            IDLE: begin
                InstrReady = 1'b1;
            end
            EXEC: begin
                Opcode = ir;
                Cin    = carry_op & psr_q[0];
            end
            WB: begin
                Opcode  = ir;
                Cin     = carry_op & psr_q[0];
                RegWrEn = (alu_code != CMP_OP);
            end
            default: begin
                InstrReady = 1'b0;
            end
        endcase
    end

    assign Psr        = psr_q;
    assign InstrCount = count_q;
    assign StateDbg   = state;

endmodule

// File: tb/tb_op_sequencer.sv
// Randomised scoreboard bench for op_sequencer with transaction-level reference model.
module tb_op_sequencer;

  localparam logic [7:0] ADDC = 8'h57;
  localparam logic [7:0] SUBC = 8'h97;
  localparam logic [7:0] CMPC = 8'hB0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] InstrIn = 16'h0000;
  logic        InstrValid = 1'b0;
  logic        InstrReady;
  logic        Stall = 1'b0;
  logic [4:0]  Flags = 5'h00;
  logic [15:0] Opcode;
  logic        Cin;
  logic        RegWrEn;
  logic [4:0]  Psr;
  logic [15:0] InstrCount;
  logic [1:0]  StateDbg;

  op_sequencer dut (
    .Clk(Clk), .Reset(Reset), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Stall(Stall), .Flags(Flags), .Opcode(Opcode),
    .Cin(Cin), .RegWrEn(RegWrEn), .Psr(Psr), .InstrCount(InstrCount),
    .StateDbg(StateDbg)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] op;
    logic        cin;
    logic        wr;
    logic [7:0]  cycles;
    logic [4:0]  psr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  model_psr = 5'h00;
  logic [15:0] model_count = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: call at posedge+1 with the DUT in IDLE
  task automatic issue(input logic [15:0] w, input int stall, input logic [4:0] f,
                       input logic keep_valid);
    exp_t e;
    logic [7:0] alu;
    alu = {w[15:12], w[7:4]};
    e.op = w;
    e.cin = ((alu == ADDC) || (alu == SUBC)) ? model_psr[0] : 1'b0;
    e.wr = (alu != CMPC);
    e.cycles = 8'(stall + 2);
    model_psr = f;
    model_count = model_count + 16'd1;
    e.psr = f;
    e.cnt = model_count;
    exp_q.push_back(e);
    InstrIn = w;
    InstrValid = 1'b1;
    Stall = 1'($urandom_range(0, 1));
    Flags = 5'($urandom);
    @(posedge Clk); #1;
    for (int i = 0; i <= stall; i++) begin
      Stall = (i < stall);
      Flags = 5'($urandom);
      InstrValid = 1'($urandom);
      InstrIn = 16'($urandom);
      @(posedge Clk); #1;
    end
    Stall = 1'($urandom);
    Flags = f;
    InstrValid = keep_valid;
    InstrIn = 16'($urandom);
    @(posedge Clk); #1;
  endtask

  // monitor / scoreboard
  exp_t cur;
  logic active = 1'b0;
  int   act_n = 0;
  int   wr_n = 0;
  int   wr_at = 0;

  always @(negedge Clk) begin
    if (mon_en && !Reset) begin
      if (!InstrReady) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_accept: got opcode %0h expected no instruction", Opcode);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          active = 1'b1;
          act_n = 0;
          wr_n = 0;
          wr_at = 0;
        end
        act_n++;
        check("opcode", 32'(Opcode), 32'(cur.op));
        check("cin", 32'(Cin), 32'(cur.cin));
        if (RegWrEn) begin
          wr_n++;
          wr_at = act_n;
        end
      end else begin
        check("idle_opcode", 32'(Opcode), 0);
        check("idle_regwren", 32'(RegWrEn), 0);
        check("idle_cin", 32'(Cin), 0);
        if (active) begin
          check("busy_cycles", act_n, 32'(cur.cycles));
          check("wr_pulses", wr_n, 32'(cur.wr));
          check("wr_position", wr_at, cur.wr ? 32'(cur.cycles) : 0);
          check("psr", 32'(Psr), 32'(cur.psr));
          check("instr_count", 32'(InstrCount), 32'(cur.cnt));
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int stall;
    int sel;
    int guard;
    logic [15:0] w;
    logic kv;

    // reset state
    #3;
    check("rst_opcode", 32'(Opcode), 0);
    check("rst_regwren", 32'(RegWrEn), 0);
    check("rst_cin", 32'(Cin), 0);
    check("rst_psr", 32'(Psr), 0);
    check("rst_count", 32'(InstrCount), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("ready_after_reset", 32'(InstrReady), 1);
    mon_en = 1'b1;

    // directed cases
    issue(16'h0512, 0, 5'h00, 1'b0);
    check("count_first", 32'(InstrCount), 1);
    check("ready_back", 32'(InstrReady), 1);
    issue(16'h0120, 0, 5'h01, 1'b0);
    issue(16'h5172, 0, 5'h03, 1'b0);
    issue(16'h0120, 0, 5'h00, 1'b0);
    issue(16'h5172, 0, 5'h01, 1'b0);
    issue(16'h9274, 0, 5'h1f, 1'b0);
    issue(16'hB304, 0, 5'h04, 1'b0);
    check("psr_after_cmp", 32'(Psr), 32'h04);
    issue(16'h0a31, 4, 5'h02, 1'b0);

    // asynchronous reset in the middle of EXEC
    @(negedge Clk); #1;
    mon_en = 1'b0;
    InstrIn = 16'h1234;
    InstrValid = 1'b1;
    Stall = 1'b1;
    @(posedge Clk); #1;
    InstrValid = 1'b0;
    check("pre_abort_opcode", 32'(Opcode), 32'h1234);
    #2;
    Reset = 1'b1;
    #1;
    check("abort_opcode", 32'(Opcode), 0);
    check("abort_regwren", 32'(RegWrEn), 0);
    check("abort_psr", 32'(Psr), 0);
    check("abort_count", 32'(InstrCount), 0);
    check("abort_ready", 32'(InstrReady), 1);
    @(posedge Clk); #1;
    Reset = 1'b0;
    Stall = 1'b0;
    check("ready_after_abort", 32'(InstrReady), 1);
    repeat (5) begin
      @(negedge Clk);
      check("no_wr_after_abort", 32'(RegWrEn), 0);
      check("count_after_abort", 32'(InstrCount), 0);
    end
    model_psr = 5'h00;
    model_count = 16'h0000;
    @(posedge Clk); #1;

    // continuous valid: one acceptance per three cycles
    Flags = 5'h00;
    Stall = 1'b0;
    InstrIn = 16'h0512;
    InstrValid = 1'b1;
    acc = 0;
    repeat (30) begin
      @(negedge Clk);
      if (InstrReady) acc++;
    end
    InstrValid = 1'b0;
    check("stream_accepts", acc, 10);
    @(posedge Clk); #1;
    model_count = model_count + 16'd10;
    model_psr = 5'h00;
    check("stream_count", 32'(InstrCount), 32'(model_count));
    check("stream_psr", 32'(Psr), 0);
    mon_en = 1'b1;

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      sel = $urandom_range(0, 5);
      w = 16'($urandom);
      if (sel == 0) begin
        w[15:12] = 4'h5; w[7:4] = 4'h7;
      end else if (sel == 1) begin
        w[15:12] = 4'h9; w[7:4] = 4'h7;
      end else if (sel == 2) begin
        w[15:12] = 4'hB; w[7:4] = 4'h0;
      end
      kv = 1'($urandom_range(0, 1));
      issue(w, stall, 5'($urandom), kv);
      if (!kv) begin
        repeat ($urandom_range(0, 2)) begin
          InstrIn = 16'($urandom);
          @(posedge Clk); #1;
        end
      end
    end
    InstrValid = 1'b0;

    guard = 0;
    while ((exp_q.size() != 0 || active) && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0 || active) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    check("final_count", 32'(InstrCount), 32'(model_count));
    check("final_psr", 32'(Psr), 32'(model_psr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL provide parameter ADDC_OP, default 8'h57, meaning the 8-bit ALU code {Opcode[15:12],Opcode[7:4]} for add-with-carry, whose Cin is taken from Psr carry.
REQ-002 SHALL provide parameter SUBC_OP, default 8'h97, meaning the ALU code for subtract-with-borrow, whose Cin is taken from Psr carry.
REQ-003 SHALL provide parameter CMP_OP, default 8'hB0, meaning the ALU code for compare, which updates Psr but never writes a register.
REQ-004 SHALL provide port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port Reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL provide port InstrIn, input, 16, the instruction word offered by the fetch side.
REQ-007 SHALL provide port InstrValid, input, 1, meaning InstrIn is valid this cycle.
REQ-008 SHALL provide port InstrReady, output, 1, meaning the sequencer accepts InstrIn this cycle.
REQ-009 SHALL provide port Stall, input, 1, meaning hold the current instruction in EXEC.
REQ-010 SHALL provide port Flags, input, 5, the datapath ALU flags, bit 0 = carry.
REQ-011 SHALL provide port Opcode, output, 16, the instruction word driven to the datapath.
REQ-012 SHALL provide port Cin, output, 1, the carry-in driven to the datapath.
REQ-013 SHALL provide port RegWrEn, output, 1, the register-file write strobe for the destination Opcode[11:8].
REQ-014 SHALL provide port Psr, output, 5, the registered processor status (latched Flags).
REQ-015 SHALL provide port InstrCount, output, 16, the number of retired instructions.

Function
REQ-016 SHALL implement states IDLE, EXEC, WB, encoded as a registered state machine.
REQ-017 In IDLE, SHALL assert InstrReady=1; RegWrEn=0; Opcode=16'h0000.
REQ-018 On a rising edge with InstrValid=1 and InstrReady=1, SHALL load InstrIn into the instruction register and move IDLE->EXEC.
REQ-019 In EXEC and WB, SHALL drive Opcode from the instruction register and hold InstrReady=0; InstrIn and InstrValid are ignored.
REQ-020 In EXEC, SHALL move to WB on the next edge when Stall=0 and remain in EXEC while Stall=1.
REQ-021 In WB, SHALL assert RegWrEn=1 for exactly one cycle unless the ALU code equals CMP_OP, in which case RegWrEn=0.
REQ-022 At the WB->IDLE edge, SHALL latch Flags into Psr for every instruction, including CMP_OP.
REQ-023 At the WB->IDLE edge, SHALL increment InstrCount by 1, wrapping 16'hFFFF->16'h0000.
REQ-024 Cin SHALL equal Psr[0] when the ALU code is ADDC_OP or SUBC_OP, else 0; Cin SHALL be 0 in IDLE.
REQ-025 SHALL make Cin a function of Psr as latched before the instruction, unaffected by Flags changing during EXEC/WB.
REQ-026 Throughput SHALL be one instruction per 3 cycles with Stall=0 (accept edge, EXEC, WB); Stall=1 in WB has no effect.
REQ-027 SHALL accept a new instruction only in IDLE; back-to-back valid words are held by the fetch side until InstrReady=1.

Reset
REQ-028 On Reset=1, SHALL immediately (asynchronously) force state IDLE, RegWrEn=0, Cin=0, Opcode=0, Psr=0, InstrCount=0, instruction register=0.
REQ-029 Reset asserted during EXEC or WB SHALL abort the instruction: no write strobe, no Psr update, no count increment.
REQ-030 After Reset deasserts, InstrReady SHALL be 1 in the first cycle.

Verification
REQ-031 Reset, then InstrIn=16'h0512 with InstrValid for 1 cycle -> Opcode=16'h0512 for 2 cycles, RegWrEn=1 only in 3rd cycle, InstrCount=1, InstrReady back to 1.
REQ-032 Psr[0]=1 preloaded via prior op with Flags=5'h01, then ADDC word 16'h5172 -> Cin=1 in EXEC/WB; same word with Psr[0]=0 -> Cin=0.
REQ-033 CMP word 16'hB304 with Flags=5'h04 -> RegWrEn stays 0 throughout, Psr=5'h04 after WB, InstrCount increments.
REQ-034 Stall=1 for 4 cycles during EXEC -> Opcode held, RegWrEn stays 0 for 4 extra cycles, then single 1-cycle RegWrEn pulse.
REQ-035 Reset pulsed mid-EXEC (asynchronous, between edges) -> RegWrEn=0, Opcode=0, Psr=0, InstrCount=0 immediately; no write pulse follows.
REQ-036 65536 retired instructions from InstrCount=0 -> InstrCount wraps to 16'h0000; InstrValid held high continuously -> one acceptance per 3 cycles.
